// File: rtl/xfer_sequencer.sv
// -----------------------------------------------------------------------------
// xfer_sequencer
//
// Timed, handshaked register-transfer sequencer for the relay computer model.
// A transfer runs as: select the source, let the bus settle, pulse load on
// one or more destinations, hold the select, then release. Illegal requests
// are accepted and immediately rejected with a one-cycle err pulse.
//
// Ports:
//   clock       in   rising-edge system clock
//   reset_n     in   asynchronous active-low reset
//   req_valid   in   transfer request present
//   req_ready   out  sequencer idle and able to accept a request
//   req_src     in   source register index
//   req_dst     in   destination mask, bit i loads register i
//   sel         out  one-hot source select to the register file
//   load        out  destination load strobes
//   busy        out  transfer in progress
//   done        out  one-cycle pulse when a legal transfer completes
//   err         out  one-cycle pulse when an illegal request is rejected
//   xfer_count  out  completed legal transfers, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module xfer_sequencer #(
    parameter int NUM_REGS  = 10,
    parameter int SEL_W     = $clog2(NUM_REGS),
    parameter int SETUP_CYC = 2,
    parameter int LOAD_CYC  = 1,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SEL_W-1:0]    req_src,
    input  logic [NUM_REGS-1:0] req_dst,
    output logic [NUM_REGS-1:0] sel,
    output logic [NUM_REGS-1:0] load,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    xfer_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    // Phase counter only needs to count down from the longest phase length.
    localparam int MAX_SL  = (SETUP_CYC > LOAD_CYC) ? SETUP_CYC : LOAD_CYC;
    localparam int MAX_CYC = (MAX_SL > HOLD_CYC) ? MAX_SL : HOLD_CYC;
    localparam int PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [PH_W-1:0]  PH_ZERO   = PH_W'(0);
    localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0]  SETUP_LD  = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0]  LOAD_LD   = PH_W'(LOAD_CYC - 1);
    localparam logic [PH_W-1:0]  HOLD_LD   = PH_W'((HOLD_CYC > 0) ? (HOLD_CYC - 1) : 0);
    localparam logic             SKIP_HOLD = (HOLD_CYC == 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // One-hot decode of a source index; out-of-range indices decode to zero.
    function automatic logic [NUM_REGS-1:0] decode_src(input logic [SEL_W-1:0] src);
        decode_src = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            decode_src[i] = (src == SEL_W'(i));
        end
    endfunction

    // A request is legal when the source exists, at least one destination is
    // named, and the source is not also a destination.
    function automatic logic is_legal(input logic [NUM_REGS-1:0] src_oh,
                                      input logic [NUM_REGS-1:0] dst);
        is_legal = (|src_oh) && (|dst) && !(|(src_oh & dst));
    endfunction

    logic [1:0]          state_r,  state_s;
    logic [PH_W-1:0]     phase_r,  phase_s;
    logic [NUM_REGS-1:0] sel_r,    sel_s;
    logic [NUM_REGS-1:0] load_r,   load_s;
    logic [NUM_REGS-1:0] dst_r,    dst_s;
    logic [CNT_W-1:0]    count_r,  count_s;
    logic                done_r,   done_s;
    logic                err_r,    err_s;
    logic                busy_r;
    logic                ready_r;
    logic [NUM_REGS-1:0] src_oh_s;

    assign src_oh_s = decode_src(req_src);

    // Next-state and next-output computation for the transfer sequence.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        sel_s   = sel_r;
        load_s  = load_r;
        dst_s   = dst_r;
        count_s = count_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                sel_s  = {NUM_REGS{1'b0}};
                load_s = {NUM_REGS{1'b0}};
                if (req_valid) begin
                    if (is_legal(src_oh_s, req_dst)) begin
                        state_s = SETUP;
                        phase_s = SETUP_LD;
                        sel_s   = src_oh_s;
                        dst_s   = req_dst;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (phase_r == PH_ZERO) begin
                    state_s = LOAD;
                    phase_s = LOAD_LD;
                    load_s  = dst_r;
                end else begin
                    phase_s = phase_r - PH_ONE;
                end
            end
            LOAD: begin
                if (phase_r == PH_ZERO) begin
                    load_s = {NUM_REGS{1'b0}};
                    if (SKIP_HOLD) begin
                        state_s = IDLE;
                        sel_s   = {NUM_REGS{1'b0}};
                        done_s  = 1'b1;
                        count_s = count_r + CNT_ONE;
                    end else begin
                        state_s = HOLD;
                        phase_s = HOLD_LD;
                    end
                end else begin
                    phase_s = phase_r - PH_ONE;
                end
            end
            HOLD: begin
                if (phase_r == PH_ZERO) begin
                    state_s = IDLE;
                    sel_s   = {NUM_REGS{1'b0}};
                    done_s  = 1'b1;
                    count_s = count_r + CNT_ONE;
                end else begin
                    phase_s = phase_r - PH_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                phase_s = PH_ZERO;
                sel_s   = {NUM_REGS{1'b0}};
                load_s  = {NUM_REGS{1'b0}};
            end
        endcase
    end

    // State and output registers; busy/ready are registered from the next
    // state so they line up with sel and load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            phase_r <= PH_ZERO;
            sel_r   <= {NUM_REGS{1'b0}};
            load_r  <= {NUM_REGS{1'b0}};
            dst_r   <= {NUM_REGS{1'b0}};
            count_r <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            sel_r   <= sel_s;
            load_r  <= load_s;
            dst_r   <= dst_s;
            count_r <= count_s;
            done_r  <= done_s;
            err_r   <= err_s;
            busy_r  <= (state_s != IDLE);
            ready_r <= (state_s == IDLE);
        end
    end

    assign sel        = sel_r;
    assign load       = load_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign req_ready  = ready_r;
    assign xfer_count = count_r;

endmodule

// File: tb/tb_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_xfer_sequencer
//
// Two sequencer instances share stimulus: one with default parameters and one
// with SETUP_CYC=1, LOAD_CYC=3, HOLD_CYC=0, CNT_W=2. Outputs of the instance
// under test are compared every cycle against a model that tracks only the
// number of cycles since a legal accept and derives sel/load/done from the
// documented timing windows.
// -----------------------------------------------------------------------------
module tb_xfer_sequencer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_src = 4'd0;
    logic [9:0] req_dst = 10'd0;

    logic       a_ready, a_busy, a_done, a_err;
    logic [9:0] a_sel, a_load;
    logic [15:0] a_count;
    logic       b_ready, b_busy, b_done, b_err;
    logic [9:0] b_sel, b_load;
    logic [1:0] b_count;

    xfer_sequencer dut_a (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(a_ready),
        .req_src(req_src), .req_dst(req_dst), .sel(a_sel), .load(a_load),
        .busy(a_busy), .done(a_done), .err(a_err), .xfer_count(a_count)
    );

    xfer_sequencer #(.NUM_REGS(10), .SETUP_CYC(1), .LOAD_CYC(3), .HOLD_CYC(0), .CNT_W(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(b_ready),
        .req_src(req_src), .req_dst(req_dst), .sel(b_sel), .load(b_load),
        .busy(b_busy), .done(b_done), .err(b_err), .xfer_count(b_count)
    );

    always #5 clock = ~clock;

    // Outputs of whichever instance is under test.
    logic        use_b = 1'b0;
    logic [9:0]  c_sel, c_load;
    logic        c_ready, c_busy, c_done, c_err;
    logic [15:0] c_count;
    assign c_sel   = use_b ? b_sel   : a_sel;
    assign c_load  = use_b ? b_load  : a_load;
    assign c_ready = use_b ? b_ready : a_ready;
    assign c_busy  = use_b ? b_busy  : a_busy;
    assign c_done  = use_b ? b_done  : a_done;
    assign c_err   = use_b ? b_err   : a_err;
    assign c_count = use_b ? {14'd0, b_count} : a_count;

    // Timing parameters of the instance under test.
    int S = 2, L = 1, H = 1, CW = 16;

    int checks = 0;
    int failures = 0;
    string phase_tag = "reset";

    // Model: m_k = cycles since a legal accept (0 when idle).
    int         m_k = 0;
    logic [3:0] m_src = 4'd0;
    logic [9:0] m_dst = 10'd0;
    bit         e_done = 1'b0;
    bit         e_err = 1'b0;
    int         m_count = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] oh(input logic [3:0] s);
        oh = 10'd0;
        if (s < 4'd10) oh[s] = 1'b1;
    endfunction

    task automatic compare_outputs();
        logic [9:0] es;
        logic [9:0] el;
        es = (m_k != 0) ? oh(m_src) : 10'd0;
        el = (m_k >= S + 1 && m_k <= S + L) ? m_dst : 10'd0;
        check_val({phase_tag, ".sel"},   32'(c_sel),   32'(es));
        check_val({phase_tag, ".load"},  32'(c_load),  32'(el));
        check_val({phase_tag, ".busy"},  32'(c_busy),  32'(m_k != 0));
        check_val({phase_tag, ".ready"}, 32'(c_ready), 32'(m_k == 0));
        check_val({phase_tag, ".done"},  32'(c_done),  32'(e_done));
        check_val({phase_tag, ".err"},   32'(c_err),   32'(e_err));
        check_val({phase_tag, ".count"}, 32'(c_count), 32'(m_count));
    endtask

    // Advance one clock: update the model at the rising edge, compare at the
    // falling edge.
    task automatic tick();
        bit acc;
        bit legal;
        acc = req_valid && (m_k == 0) && reset_n;
        @(posedge clock);
        e_done = 1'b0;
        e_err  = 1'b0;
        if (!reset_n) begin
            m_k = 0;
            m_count = 0;
        end else if (m_k != 0) begin
            if (m_k == S + L + H) begin
                m_k = 0;
                e_done = 1'b1;
                m_count = (m_count + 1) % (1 << CW);
            end else begin
                m_k++;
            end
        end else if (acc) begin
            legal = (req_src < 4'd10) && (req_dst != 10'd0) && ((oh(req_src) & req_dst) == 10'd0);
            if (legal) begin
                m_k = 1;
                m_src = req_src;
                m_dst = req_dst;
            end else begin
                e_err = 1'b1;
            end
        end
        @(negedge clock);
        compare_outputs();
    endtask

    task automatic run_req(input logic [3:0] src, input logic [9:0] dst);
        req_valid = 1'b1;
        req_src = src;
        req_dst = dst;
        tick();
        req_valid = 1'b0;
        while (m_k != 0) tick();
        tick();
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_src   = 4'($urandom_range(0, 11));
            req_dst   = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
            tick();
        end
        req_valid = 1'b0;
        while (m_k != 0) tick();
        tick();
    endtask

    initial begin
        int base;
        // Reset state
        @(negedge clock);
        compare_outputs();
        reset_n = 1'b1;
        tick();

        phase_tag = "single";
        run_req(4'd2, 10'b0000000001);
        check_val("single.count_one", 32'(c_count), 32'd1);

        phase_tag = "multi";
        run_req(4'd0, 10'b0000110100);

        phase_tag = "illegal";
        run_req(4'd3, 10'b0000001000);
        run_req(4'd1, 10'b0000001000);
        run_req(4'd12, 10'b0000000001);
        run_req(4'd4, 10'b1000000000);
        run_req(4'd0, 10'b0000000000);
        run_req(4'd9, 10'b0111111111);

        phase_tag = "b2b";
        base = m_count;
        req_valid = 1'b1;
        req_src = 4'd1;
        req_dst = 10'b0000010000;
        tick();
        req_src = 4'd6;
        req_dst = 10'b0000000110;
        repeat (S + L + H + 1) tick();
        req_valid = 1'b0;
        while (m_k != 0) tick();
        tick();
        check_val("b2b.count_plus2", 32'(c_count), 32'((base + 2) % (1 << CW)));

        phase_tag = "random_a";
        random_cycles(400);

        // Reset in the middle of the load phase
        phase_tag = "rst_mid";
        req_valid = 1'b1;
        req_src = 4'd5;
        req_dst = 10'b0000000011;
        tick();
        req_valid = 1'b0;
        while (m_k != S + 1) tick();
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_mid.sel_now",   32'(c_sel),   32'd0);
        check_val("rst_mid.load_now",  32'(c_load),  32'd0);
        check_val("rst_mid.ready_now", 32'(c_ready), 32'd1);
        check_val("rst_mid.count_now", 32'(c_count), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        // Second configuration: SETUP=1, LOAD=3, HOLD=0, 2-bit counter
        phase_tag = "sweep";
        reset_n = 1'b0;
        use_b = 1'b1;
        S = 1; L = 3; H = 0; CW = 2;
        tick();
        reset_n = 1'b1;
        tick();
        run_req(4'd7, 10'b0000000001);
        run_req(4'd0, 10'b1000000000);
        run_req(4'd3, 10'b0011000000);
        run_req(4'd9, 10'b0000000100);
        run_req(4'd2, 10'b0000001000);
        check_val("sweep.count_wrap", 32'(c_count), 32'd1);

        phase_tag = "random_b";
        random_cycles(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xfer_sequencer.md
Name: xfer_sequencer

Overview:
Parametrised register-transfer sequencer for the relay computer model. It replaces static per-register load/select lines with a timed, handshaked sequence: select source, settle, pulse load on one or more destinations, hold, release. It sits between the instruction-cycle controller and the register file (A, B, C, D, M1, M2, X, Y, J1, J2, INST, PC, INC …). It generalises register count and relay timing, and adds multi-destination loads, error detection and a transfer counter.

Parameters:
NUM_REGS, 10, number of registers on the bus (2..64).
SEL_W, $clog2(NUM_REGS), width of the source index. Derived; not overridden.
SETUP_CYC, 2, cycles the select is asserted before load (>=1).
LOAD_CYC, 1, cycles load is asserted (>=1).
HOLD_CYC, 1, cycles the select is held after load drops (>=0; 0 skips HOLD).
CNT_W, 16, width of the completed-transfer counter.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
req_valid  in  1  transfer request present.
req_ready  out  1  sequencer can accept a request.
req_src  in  SEL_W  source register index.
req_dst  in  NUM_REGS  destination mask; bit i loads register i.
sel  out  NUM_REGS  one-hot source select to register file.
load  out  NUM_REGS  destination load strobes.
busy  out  1  transfer in progress (state != IDLE).
done  out  1  one-cycle pulse on completion of a legal transfer.
err  out  1  one-cycle pulse on rejection of an illegal request.
xfer_count  out  CNT_W  count of completed legal transfers.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; sel=0, load=0, done=0, err=0, xfer_count=0, busy=0, req_ready=1. Outputs clear immediately, mid-transfer included. There is no partial completion and no done pulse.
- Handshake: a request is accepted on a rising edge with req_valid & req_ready. req_ready = (state==IDLE). req_src and req_dst are latched at accept. Inputs are ignored while busy.
- Legality check at accept. The request is illegal if any of these hold: req_src >= NUM_REGS, req_dst==0, or req_dst[req_src]==1 (load and select on the same register).
- Illegal request: the handshake completes and the state stays IDLE. err=1 for the cycle after accept. sel, load and xfer_count are unchanged.
- FSM states and transitions:
  - IDLE -> SETUP on a legal accept.
  - SETUP: sel=onehot(src), load=0, for SETUP_CYC cycles, then -> LOAD.
  - LOAD: sel=onehot(src), load=latched dst, for LOAD_CYC cycles, then -> HOLD, or -> IDLE if HOLD_CYC==0.
  - HOLD: sel=onehot(src), load=0, for HOLD_CYC cycles, then -> IDLE.
- Completion: on the final transition into IDLE, done=1 for exactly one cycle (the first IDLE cycle) and xfer_count increments.
- Timing: with accept at edge 0, sel is high for edges 1..S+L+H, load for edges S+1..S+L, and done in cycle S+L+H+1.
- Back-to-back: a request may be accepted in the done cycle. Its SETUP begins next cycle, so sel has a 1-cycle gap of zero between transfers. sel is never active for two sources in the same cycle.
- All outputs are registered. load is never asserted unless sel is also asserted. load is never asserted on the selected register.
- xfer_count wraps modulo 2^CNT_W with no saturation.
- The internal phase counter is sized for max(SETUP_CYC, LOAD_CYC, HOLD_CYC) and reloads on each state entry.
- done and err never assert in the same cycle.

Test Plan:
1. Defaults: src=2, dst=10'b0000000001 -> sel[2]=1 for 4 cycles; load[0]=1 only in cycle 3 after accept; done in cycle 5; xfer_count=1.
2. Multi-dest: src=0, dst=10'b0000110100 -> load[2], load[4], load[5] pulse together in the LOAD cycle; sel=10'b0000000001 throughout.
3. Illegal requests, each followed by a legal one:
   - src=3, dst=10'b0000001000 -> err pulse one cycle after accept; sel=load=0; xfer_count unchanged.
   - src=12 (NUM_REGS=10) -> same response.
   - dst=0 -> same response.
4. Back-to-back: req_valid held high with two legal requests -> second accepted in the done cycle; exactly one zero cycle on sel between transfers; xfer_count=2.
5. Reset mid-LOAD: reset_n=0 while load active -> sel=load=0 immediately; no done; xfer_count=0; req_ready=1 after release.
6. Parameter sweep SETUP_CYC=1, LOAD_CYC=3, HOLD_CYC=0, CNT_W=2 -> sel for 4 cycles, load for the last 3; five transfers give xfer_count=1 (wrap).
